branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor for the RV32I pipelined core. It sits between decode and fetch. During decode it looks up the PC of the instruction in decode and drives `prediction_source_D` and `predicted_PC_D` into the fetch stage's predictor mux. During execute it is trained with the resolved branch outcome and flags mispredictions. Storage is a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.

## Interface
- `PC_WIDTH`, 32, PC/address width.
- `ENTRIES`, 16, BTB entries; power of two, ≥2. `INDEX_BITS = $clog2(ENTRIES)`; `TAG_BITS = PC_WIDTH-INDEX_BITS-2`.

- `clk` in 1: clock.
- `async_rst_n` in 1: one clock; reset is asynchronous, active-low.
- `valid_D` in 1: decode holds a real instruction (not a bubble or flush).
- `is_branch_D` in 1: decoded instruction is a conditional branch or JAL.
- `PC_D` in PC_WIDTH: PC of the decode instruction.
- `update_valid_E` in 1: a branch/JAL resolves in execute this cycle.
- `PC_E` in PC_WIDTH: PC of the resolving instruction.
- `branch_taken_E` in 1: resolved direction.
- `target_E` in PC_WIDTH: resolved target (ALU result).
- `predicted_taken_E` in 1: prediction carried down the pipe for this instruction.
- `predicted_PC_E` in PC_WIDTH: predicted target carried down the pipe.
- `prediction_source_D` out 1: 1 selects `predicted_PC_D` as the fetch PC.
- `predicted_PC_D` out PC_WIDTH: predicted target.
- `mispredict_E` out 1: resolved outcome differs from the prediction.

## Operation
- Index is `PC[INDEX_BITS+1:2]`. Tag is `PC[PC_WIDTH-1:INDEX_BITS+2]`. Each entry holds valid, tag, target and a 2-bit counter.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Counter bit 1 gives the predicted direction.
- Lookup is combinational:
  - `hit_D = entry.valid & (entry.tag == tag(PC_D))`.
  - `prediction_source_D = valid_D & is_branch_D & hit_D & counter[1]`.
  - `predicted_PC_D = entry.target` when `prediction_source_D` is 1, else 0.
- Update happens on the clock edge when `update_valid_E` is 1, at `index(PC_E)`:
  - Hit, taken: counter increments and saturates at 11; target is overwritten with `target_E`.
  - Hit, not taken: counter decrements and saturates at 00; target is unchanged.
  - Miss, taken: the entry is allocated or replaced. valid=1, tag=tag(PC_E), target=`target_E`, counter=10.
  - Miss, not taken: no change.
- `mispredict_E = update_valid_E & ((branch_taken_E != predicted_taken_E) | (branch_taken_E & (target_E != predicted_PC_E)))`. This is combinational.
- The predictor performs no flush or redirect itself. The hazard unit consumes `mispredict_E`.

## Timing
- Lookup latency is 0 cycles (same cycle as `PC_D`). Update takes effect at the next rising edge.
- Reset, asynchronous: all valid bits are 0 and all counters are 01. Outputs then read `prediction_source_D`=0 and `predicted_PC_D`=0. `mispredict_E` depends only on inputs.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. There is no write-to-read bypass.
- Aliasing: two PCs with the same index and different tags replace each other, but only on a taken miss.
- Reset asserted mid-operation clears the table immediately. Any update in flight is lost.
- A write occurs only when `update_valid_E`=1. All other inputs are ignored while it is 0.

## Configuration
- `BP_STATS_EN` defined: adds three 32-bit output ports, all reset to 0 and wrapping on overflow:
  - `stat_lookups`: increments when `valid_D & is_branch_D`.
  - `stat_hits`: increments when `valid_D & is_branch_D & hit_D`.
  - `stat_mispredicts`: increments when `mispredict_E`.
- `BP_STATS_EN` undefined: the ports and counters do not exist. Prediction behaviour is identical in both cases.

## Structure
- `bp_pkg` contains:
  - enum `bp_counter_t` {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T};
  - struct `btb_entry_t` {valid, tag, target, counter}, parameterised through localparam widths;
  - constant `BP_COUNTER_RESET = WEAK_NT`;
  - constant `BP_COUNTER_ALLOC = WEAK_T`.
- Sub-module `sat_counter_2b`: a purely combinational next-state function with inputs current counter and taken, and output next counter. It is instantiated once in the update path.
- The table is an array of `btb_entry_t` held in flip-flops with asynchronous reset. No SRAM macro is used.

## Test plan
- Reset then lookup: `valid_D`=1, `is_branch_D`=1, `PC_D`=0x100 → `prediction_source_D`=0, `predicted_PC_D`=0.
- Taken miss then lookup: update `PC_E`=0x100, taken, `target_E`=0x180 → next cycle `PC_D`=0x100 gives source=1, `predicted_PC_D`=0x180.
- Saturation: four taken updates at 0x100 → counter 11. Then one not-taken → 10, still predicts 0x180. A second not-taken → 01, source=0.
- Alias: ENTRIES=16, taken miss at 0x140 (same index as 0x100) → 0x100 lookup misses and 0x140 hits. A not-taken miss at 0x100 leaves 0x140 intact.
- Mispredict: `predicted_taken_E`=1, `predicted_PC_E`=0x180, taken, `target_E`=0x1C0 → `mispredict_E`=1. With `target_E`=0x180 → 0. With not taken → 1.
- Same-cycle hazard, with `BP_STATS_EN` defined: a lookup and a taken-miss update at 0x200 in the same cycle → that lookup returns source=0 while the next cycle's lookup hits. `stat_lookups`=2, `stat_hits`=1.

Source files
------------

// File: rtl/bp_pkg.sv
// +-----------------------------------------------------------------------+
// | bp_pkg: shared types and constants for the BTB branch predictor       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package bp_pkg;

  localparam int BP_PC_WIDTH   = 32;
  localparam int BP_ENTRIES    = 16;
  localparam int BP_INDEX_BITS = $clog2(BP_ENTRIES);
  localparam int BP_TAG_BITS   = BP_PC_WIDTH - BP_INDEX_BITS - 2;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_counter_t;

  typedef struct packed {
    logic                     valid;
    logic [BP_TAG_BITS-1:0]   tag;
    logic [BP_PC_WIDTH-1:0]   target;
    bp_counter_t              counter;
  } btb_entry_t;

  localparam bp_counter_t BP_COUNTER_RESET = WEAK_NT;
  localparam bp_counter_t BP_COUNTER_ALLOC = WEAK_T;

endpackage

`default_nettype wire

// File: rtl/sat_counter_2b.sv
// +-----------------------------------------------------------------------+
// | sat_counter_2b: next-state function of a 2-bit saturating counter     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module sat_counter_2b
  import bp_pkg::*;
(
  input  bp_counter_t i_count,
  input  logic        i_taken,
  output bp_counter_t o_count
);

  always_comb begin
    o_count = i_count;
    case (i_count)
      STRONG_NT: o_count = i_taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   o_count = i_taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    o_count = i_taken ? STRONG_T : WEAK_NT;
      STRONG_T:  o_count = i_taken ? STRONG_T : WEAK_T;
      default:   o_count = i_count;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// +-----------------------------------------------------------------------+
// | branch_predictor: direct-mapped BTB with 2-bit counters, 0-cycle      |
// | lookup in decode, training in execute. Optional BP_STATS_EN counters. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module branch_predictor
  import bp_pkg::*;
#(
  // Entry field widths come from bp_pkg; change them there together with these.
  parameter int PC_WIDTH = BP_PC_WIDTH,
  parameter int ENTRIES  = BP_ENTRIES
) (
  input  logic                clk,
  input  logic                async_rst_n,
  input  logic                valid_D,
  input  logic                is_branch_D,
  input  logic [PC_WIDTH-1:0] PC_D,
  input  logic                update_valid_E,
  input  logic [PC_WIDTH-1:0] PC_E,
  input  logic                branch_taken_E,
  input  logic [PC_WIDTH-1:0] target_E,
  input  logic                predicted_taken_E,
  input  logic [PC_WIDTH-1:0] predicted_PC_E,
  output logic                prediction_source_D,
  output logic [PC_WIDTH-1:0] predicted_PC_D,
  output logic                mispredict_E
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS   = PC_WIDTH - INDEX_BITS - 2;

  btb_entry_t r_btb [ENTRIES];

  logic [INDEX_BITS-1:0] w_idx_D, w_idx_E;
  logic [TAG_BITS-1:0]   w_tag_D, w_tag_E;
  btb_entry_t            w_entry_D, w_entry_E;
  logic                  w_hit_D, w_hit_E, w_lookup_D;
  bp_counter_t           w_next_count;
  logic                  w_unused_pc_lsbs;

  assign w_idx_D   = PC_D[INDEX_BITS+1:2];
  assign w_tag_D   = PC_D[PC_WIDTH-1:INDEX_BITS+2];
  assign w_idx_E   = PC_E[INDEX_BITS+1:2];
  assign w_tag_E   = PC_E[PC_WIDTH-1:INDEX_BITS+2];
  assign w_unused_pc_lsbs = ^{PC_D[1:0], PC_E[1:0]};

  assign w_entry_D  = r_btb[w_idx_D];
  assign w_entry_E  = r_btb[w_idx_E];
  assign w_hit_D    = w_entry_D.valid & (w_entry_D.tag == w_tag_D);
  assign w_hit_E    = w_entry_E.valid & (w_entry_E.tag == w_tag_E);
  assign w_lookup_D = valid_D & is_branch_D;

  assign prediction_source_D = w_lookup_D & w_hit_D & w_entry_D.counter[1];
  assign predicted_PC_D      = prediction_source_D ? w_entry_D.target : '0;

  assign mispredict_E = update_valid_E &
                        ((branch_taken_E != predicted_taken_E) |
                         (branch_taken_E & (target_E != predicted_PC_E)));

  sat_counter_2b u_sat_counter (
    .i_count (w_entry_E.counter),
    .i_taken (branch_taken_E),
    .o_count (w_next_count)
  );

  // Lookup reads the table directly, so a same-cycle update is seen only next cycle.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb[i].valid   <= 1'b0;
        r_btb[i].tag     <= '0;
        r_btb[i].target  <= '0;
        r_btb[i].counter <= BP_COUNTER_RESET;
      end
    end else if (update_valid_E) begin
      if (w_hit_E) begin
        r_btb[w_idx_E].counter <= w_next_count;
        if (branch_taken_E) begin
          r_btb[w_idx_E].target <= target_E;
        end
      end else if (branch_taken_E) begin
        r_btb[w_idx_E].valid   <= 1'b1;
        r_btb[w_idx_E].tag     <= w_tag_E;
        r_btb[w_idx_E].target  <= target_E;
        r_btb[w_idx_E].counter <= BP_COUNTER_ALLOC;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_lookups, r_stat_hits, r_stat_mispredicts;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_stat_lookups     <= '0;
      r_stat_hits        <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_lookup_D)           r_stat_lookups     <= r_stat_lookups + 32'd1;
      if (w_lookup_D & w_hit_D) r_stat_hits        <= r_stat_hits + 32'd1;
      if (mispredict_E)         r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_lookups     = r_stat_lookups;
  assign stat_hits        = r_stat_hits;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

`default_nettype wire
